// File: rtl/morph_erode_window.sv
// morph_erode_window
//
// Grayscale 3x3 erosion stage fed by a three-row line buffer. Each accepted
// column (top/mid/bot taps of one x position) is shifted into a 3x3 window.
// Once the window holds three columns of the current line it completes the
// neighbourhood of centre (x-1, y-1), and the minimum of its nine pixels is
// emitted. Border centres never produce output. Between frames the block
// holds the line-buffer FIFOs in reset and waits for their reset-busy flag
// to clear before it raises ready again.
//
// Ports:
//   clk            system clock
//   rst_n          asynchronous active-low reset
//   col_valid      column taps valid this cycle (only accepted in RUN)
//   col_top        pixel at (x, y-2)
//   col_mid        pixel at (x, y-1)
//   col_bot        pixel at (x, y)
//   fifo_rst_busy  line-buffer FIFO reset busy
//   rst_fifo       active-low reset to the line-buffer FIFOs
//   ready          upstream may present columns
//   pix_out        eroded pixel for centre (x-1, y-1)
//   valid_out      single-cycle strobe qualifying pix_out
//   frame_done     pulse coincident with the last valid_out of a frame

module morph_erode_window #(
  parameter int PIC_WIDTH  = 250,
  parameter int PIC_HEIGHT = 250,
  parameter int WIDTH      = 8,
  parameter int RST_CYCLES = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             col_valid,
  input  logic [WIDTH-1:0] col_top,
  input  logic [WIDTH-1:0] col_mid,
  input  logic [WIDTH-1:0] col_bot,
  input  logic             fifo_rst_busy,
  output logic             rst_fifo,
  output logic             ready,
  output logic [WIDTH-1:0] pix_out,
  output logic             valid_out,
  output logic             frame_done
);

  localparam int XW = $clog2(PIC_WIDTH);
  localparam int YW = $clog2(PIC_HEIGHT);
  localparam int CW = $clog2(RST_CYCLES + 1);

  localparam logic [XW-1:0] X_LAST = XW'(PIC_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(PIC_HEIGHT - 1);
  localparam logic [CW-1:0] C_LAST = CW'(RST_CYCLES - 1);
  localparam logic [XW-1:0] X_TWO  = XW'(2);
  localparam logic [YW-1:0] Y_TWO  = YW'(2);

  typedef enum logic [1:0] {
    ST_FIFO_RST,
    ST_WAIT,
    ST_RUN,
    ST_DRAIN
  } state_t;

  state_t state, state_next;

  logic [CW-1:0]    rst_cnt;
  logic [XW-1:0]    x;
  logic [YW-1:0]    y;
  logic             accept;
  logic             last_col;
  logic             entering_rst;
  logic [WIDTH-1:0] win [0:2][0:2];
  logic [WIDTH-1:0] row_min [0:2];
  logic [WIDTH-1:0] win_min;
  logic             win_valid;
  logic             win_last;

  assign accept       = col_valid && (state == ST_RUN);
  assign last_col     = (x == X_LAST) && (y == Y_LAST);
  assign entering_rst = (state != ST_FIFO_RST) && (state_next == ST_FIFO_RST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_FIFO_RST;
    end else begin
      state <= state_next;
    end
  end

  // DRAIN leaves in the cycle frame_done is shown, so FIFO reset starts the
  // cycle after the final output of the frame.
  always_comb begin
    state_next = state;
    rst_fifo   = 1'b1;
    ready      = 1'b0;
    case (state)
      ST_FIFO_RST: begin
        rst_fifo = 1'b0;
        if (rst_cnt == C_LAST) state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (!fifo_rst_busy) state_next = ST_RUN;
      end
      ST_RUN: begin
        ready = 1'b1;
        if (accept && last_col) state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (frame_done) state_next = ST_FIFO_RST;
      end
      default: state_next = ST_FIFO_RST;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_cnt <= '0;
    end else if (state == ST_FIFO_RST && rst_cnt != C_LAST) begin
      rst_cnt <= rst_cnt + 1'b1;
    end else begin
      rst_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x <= '0;
      y <= '0;
    end else if (entering_rst) begin
      x <= '0;
      y <= '0;
    end else if (accept) begin
      if (x == X_LAST) begin
        x <= '0;
        y <= (y == Y_LAST) ? '0 : y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

  // Column 2 is the newest column; columns x=0 and x=1 of each line refill
  // the window, so nothing from the previous line survives to an output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win[r][c] <= '0;
        end
      end
      win_valid <= 1'b0;
      win_last  <= 1'b0;
    end else begin
      if (accept) begin
        for (int r = 0; r < 3; r++) begin
          win[r][0] <= win[r][1];
          win[r][1] <= win[r][2];
        end
        win[0][2] <= col_top;
        win[1][2] <= col_mid;
        win[2][2] <= col_bot;
      end
      win_valid <= accept && (x >= X_TWO) && (y >= Y_TWO);
      win_last  <= accept && last_col;
    end
  end

  function automatic logic [WIDTH-1:0] min2(input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b);
    return (a < b) ? a : b;
  endfunction

  always_comb begin
    for (int r = 0; r < 3; r++) begin
      row_min[r] = min2(min2(win[r][0], win[r][1]), win[r][2]);
    end
    win_min = min2(min2(row_min[0], row_min[1]), row_min[2]);
  end

  // pix_out keeps the last result between strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_out    <= '0;
      valid_out  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      if (win_valid) pix_out <= win_min;
      valid_out  <= win_valid;
      frame_done <= win_valid && win_last;
    end
  end

endmodule

// File: tb/tb_morph_erode_window.sv
// tb_morph_erode_window
//
// Drives morph_erode_window with a 5x4 frame and RST_CYCLES=4. A reference
// model predicts FIFO sequencing, column acceptance and the erosion results
// from the frame rules; every cycle the outputs are compared with it, and
// directed frames are additionally compared with literal expected values.

module tb_morph_erode_window;

  localparam int PW = 5;
  localparam int PH = 4;
  localparam int WD = 8;
  localparam int RC = 4;

  localparam int P_RST   = 0;
  localparam int P_WAIT  = 1;
  localparam int P_RUN   = 2;
  localparam int P_DRAIN = 3;

  localparam int K_RAMP = 0;
  localparam int K_DARK = 1;
  localparam int K_RAND = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          col_valid = 1'b0;
  logic [WD-1:0] col_top = '0;
  logic [WD-1:0] col_mid = '0;
  logic [WD-1:0] col_bot = '0;
  logic          fifo_rst_busy = 1'b1;
  logic          rst_fifo;
  logic          ready;
  logic [WD-1:0] pix_out;
  logic          valid_out;
  logic          frame_done;

  morph_erode_window #(
    .PIC_WIDTH (PW),
    .PIC_HEIGHT(PH),
    .WIDTH     (WD),
    .RST_CYCLES(RC)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .col_valid    (col_valid),
    .col_top      (col_top),
    .col_mid      (col_mid),
    .col_bot      (col_bot),
    .fifo_rst_busy(fifo_rst_busy),
    .rst_fifo     (rst_fifo),
    .ready        (ready),
    .pix_out      (pix_out),
    .valid_out    (valid_out),
    .frame_done   (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int due;
    int val;
    bit last;
  } exp_t;

  exp_t q[$];
  int   seen [PH][PW][3];
  int   rnd  [PH][PW][3];
  int   got[$];
  int   done_val;
  int   ph, rcnt, mx, my, cyc, exp_pix;
  bit   exp_valid, exp_done, prev_done, frame_end;
  int   low_streak, last_low_len;
  int   n_total, n_pass, n_fail;
  int   ramp_exp [6];
  int   dark_exp [6];
  int   ready_cyc, steps;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    ph         = P_RST;
    rcnt       = 0;
    mx         = 0;
    my         = 0;
    cyc        = 0;
    exp_pix    = 0;
    prev_done  = 0;
    frame_end  = 0;
    low_streak = 1;
    q.delete();
  endtask

  function automatic int tap(input int kind, input int x, input int y, input int r);
    int b;
    case (kind)
      K_RAMP: begin
        b = 10 * y + x;
        return (b - 10 * (2 - r)) & 255;
      end
      K_DARK:  return (r == 1 && x == 2 && y == 2) ? 3 : 200;
      default: return rnd[y][x][r];
    endcase
  endfunction

  function automatic int window_min(input int x, input int y);
    int m = 255;
    for (int c = x - 2; c <= x; c++)
      for (int r = 0; r < 3; r++)
        if (seen[y][c][r] < m) m = seen[y][c][r];
    return m;
  endfunction

  // One clock: drive at negedge, let the posedge happen, check at negedge.
  task automatic step(input bit v, input int t, input int m, input int b);
    bit   acc;
    bit   pd;
    exp_t e;
    col_valid = v;
    col_top   = WD'(t);
    col_mid   = WD'(m);
    col_bot   = WD'(b);
    @(posedge clk);
    @(negedge clk);
    cyc++;
    pd  = prev_done;
    acc = (ph == P_RUN) && v;
    exp_valid = 0;
    exp_done  = 0;
    if (q.size() > 0 && q[0].due == cyc) begin
      exp_valid = 1;
      exp_pix   = q[0].val;
      exp_done  = q[0].last;
      void'(q.pop_front());
    end
    frame_end = 0;
    case (ph)
      P_RST: begin
        rcnt++;
        if (rcnt == RC) begin
          ph   = P_WAIT;
          rcnt = 0;
        end
      end
      P_WAIT: if (fifo_rst_busy === 1'b0) ph = P_RUN;
      P_RUN:  if (acc && mx == PW - 1 && my == PH - 1) ph = P_DRAIN;
      default: if (pd) begin
        ph        = P_RST;
        frame_end = 1;
      end
    endcase
    if (acc) begin
      seen[my][mx][0] = t;
      seen[my][mx][1] = m;
      seen[my][mx][2] = b;
      if (mx >= 2 && my >= 2) begin
        e.val  = window_min(mx, my);
        e.due  = cyc + 1;
        e.last = (mx == PW - 1 && my == PH - 1);
        q.push_back(e);
      end
      if (mx == PW - 1) begin
        mx = 0;
        my = (my == PH - 1) ? 0 : my + 1;
      end else begin
        mx++;
      end
    end
    prev_done = exp_done;
    chk("rst_fifo",   32'(rst_fifo),   32'(ph != P_RST));
    chk("ready",      32'(ready),      32'(ph == P_RUN));
    chk("valid_out",  32'(valid_out),  32'(exp_valid));
    chk("frame_done", 32'(frame_done), 32'(exp_done));
    chk("pix_out",    32'(pix_out),    32'(exp_pix));
    if (rst_fifo === 1'b0) low_streak++;
    else if (low_streak > 0) begin
      last_low_len = low_streak;
      low_streak   = 0;
    end
    if (valid_out === 1'b1) got.push_back(int'(pix_out));
    if (frame_done === 1'b1) done_val = int'(pix_out);
  endtask

  task automatic run_frame(input int kind, input int gap, input bit garbage);
    int cnt   = 0;
    int k     = 0;
    bit v;
    bit first = 1;
    bit done  = 0;
    got.delete();
    done_val = -1;
    if (kind == K_RAND)
      for (int yy = 0; yy < PH; yy++)
        for (int xx = 0; xx < PW; xx++)
          for (int r = 0; r < 3; r++)
            rnd[yy][xx][r] = $urandom_range(0, 255);
    while (!done && cnt < 300) begin
      if (ph == P_RUN) begin
        case (gap)
          0:       v = 1;
          1:       v = (k % 3 == 0);
          default: v = 1'($urandom_range(0, 1));
        endcase
        k++;
        if (v && first) begin
          chk("fifo_rst_len", 32'(last_low_len), 32'(RC));
          first = 0;
        end
        step(v, tap(kind, mx, my, 0), tap(kind, mx, my, 1), tap(kind, mx, my, 2));
      end else begin
        step(garbage, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
      end
      done = frame_end;
      cnt++;
    end
    chk("frame_timeout", 32'(done), 32'd1);
  endtask

  task automatic check_values(input string tag, input int expv [6], input int last_val);
    chk({tag, "_count"}, 32'(got.size()), 32'd6);
    for (int i = 0; i < 6; i++)
      chk({tag, "_value"}, (i < got.size()) ? 32'(got[i]) : 32'hFFFF_FFFF, 32'(expv[i]));
    chk({tag, "_done_value"}, 32'(done_val), 32'(last_val));
  endtask

  initial begin
    n_total      = 0;
    n_pass       = 0;
    n_fail       = 0;
    last_low_len = 0;
    ready_cyc    = 0;
    ramp_exp     = '{0, 1, 2, 10, 11, 12};
    dark_exp     = '{3, 3, 3, 200, 200, 200};

    // Reset values while rst_n is held low.
    rst_n         = 1'b0;
    fifo_rst_busy = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_rst_fifo",   32'(rst_fifo),   32'd0);
    chk("reset_ready",      32'(ready),      32'd0);
    chk("reset_valid_out",  32'(valid_out),  32'd0);
    chk("reset_pix_out",    32'(pix_out),    32'd0);
    chk("reset_frame_done", 32'(frame_done), 32'd0);

    // FIFO sequencing with busy held for 10 cycles after release.
    rst_n = 1'b1;
    model_reset();
    #1;
    chk("release_rst_fifo", 32'(rst_fifo), 32'd0);
    for (int i = 1; i <= 14; i++) begin
      fifo_rst_busy = (i <= 10);
      step(1'b0, 0, 0, 0);
      if (ready === 1'b1 && ready_cyc == 0) ready_cyc = i + 1;
    end
    chk("init_fifo_rst_len", 32'(last_low_len), 32'(RC));
    chk("ready_after_busy", 32'(ready_cyc - 11), 32'd1);
    fifo_rst_busy = 1'b0;

    // Ramp frame, continuous columns.
    run_frame(K_RAMP, 0, 1'b0);
    check_values("ramp", ramp_exp, 12);

    // Same frame with 1,0,0 gaps.
    run_frame(K_RAMP, 1, 1'b0);
    check_values("gapped", ramp_exp, 12);

    // Single dark pixel.
    run_frame(K_DARK, 0, 1'b0);
    check_values("dark", dark_exp, 200);

    // Back-to-back frames with col_valid held high outside RUN.
    run_frame(K_RAMP, 0, 1'b1);
    check_values("b2b_first", ramp_exp, 12);
    run_frame(K_RAMP, 0, 1'b1);
    check_values("b2b_second", ramp_exp, 12);

    // Random pixels and random gaps.
    for (int f = 0; f < 3; f++) begin
      run_frame(K_RAND, 2, 1'b1);
      chk("rand_count", 32'(got.size()), 32'd6);
    end

    // Mid-frame reset with the (1,1) result on the output.
    steps = 0;
    while (!(ph == P_RUN && mx == 3 && my == 2) && steps < 200) begin
      if (ph == P_RUN) step(1'b1, tap(K_RAMP, mx, my, 0), tap(K_RAMP, mx, my, 1), tap(K_RAMP, mx, my, 2));
      else             step(1'b0, 0, 0, 0);
      steps++;
    end
    step(1'b0, 0, 0, 0);
    chk("pre_reset_valid", 32'(valid_out), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midreset_valid_out",  32'(valid_out),  32'd0);
    chk("midreset_frame_done", 32'(frame_done), 32'd0);
    chk("midreset_rst_fifo",   32'(rst_fifo),   32'd0);
    chk("midreset_ready",      32'(ready),      32'd0);
    chk("midreset_pix_out",    32'(pix_out),    32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    #1;
    chk("midreset_release_rst_fifo", 32'(rst_fifo), 32'd0);
    run_frame(K_RAMP, 0, 1'b0);
    check_values("after_reset", ramp_exp, 12);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/morph_erode_window.md
# morph_erode_window

Downstream consumer of the three-row line buffer in the morphological-opening pipeline. Takes one vertically aligned 3-pixel column per accepted cycle and assembles a 3x3 window. It emits the grayscale erosion, the minimum of the 9 pixels, for every interior pixel of the frame. It also sequences the line-buffer FIFOs between frames: it holds them in reset, waits out their reset-busy period, then signals ready for the next frame.

## Interface
Parameters:
- PIC_WIDTH, 250, frame width in pixels (>= 3)
- PIC_HEIGHT, 250, frame height in lines (>= 3)
- WIDTH, 8, pixel width in bits
- RST_CYCLES, 8, number of clocks `rst_fifo` is held low per frame boundary (>= 1)

Ports:
- clk  in  1  system clock; single clock domain
- rst_n  in  1  asynchronous, active-low reset
- col_valid  in  1  column taps valid this cycle; ignored outside RUN
- col_top  in  WIDTH  pixel at (x, y-2)
- col_mid  in  WIDTH  pixel at (x, y-1)
- col_bot  in  WIDTH  pixel at (x, y), the current input pixel
- fifo_rst_busy  in  1  line-buffer FIFO reset busy
- rst_fifo  out  1  active-low FIFO reset to the line buffer
- ready  out  1  upstream may present pixels (high only in RUN)
- pix_out  out  WIDTH  eroded pixel for centre (x-1, y-1)
- valid_out  out  1  pix_out valid
- frame_done  out  1  one-cycle pulse coincident with the last valid_out of a frame

## Operation
- FSM states, with the outputs each state drives:
  - FIFO_RST: rst_fifo=0, ready=0; stays RST_CYCLES clocks, then goes to WAIT.
  - WAIT: rst_fifo=1, ready=0; goes to RUN on the first cycle fifo_rst_busy==0 is sampled.
  - RUN: rst_fifo=1, ready=1; goes to DRAIN on an accepted column at (PIC_WIDTH-1, PIC_HEIGHT-1).
  - DRAIN: ready=0; waits for the final valid_out/frame_done, then goes to FIFO_RST.
- State on leaving async reset: FIFO_RST.
- Accepted column: col_valid=1 while in RUN.
- Counters:
  - x counts 0..PIC_WIDTH-1 and y counts 0..PIC_HEIGHT-1; both advance only on accepted columns.
  - x wraps to 0 and y increments at x=PIC_WIDTH-1.
  - Both clear on entry to FIFO_RST.
  - Counter width is $clog2 of the dimension.
- Window: 3x3 register array.
  - Each accepted column shifts in as the newest column and the oldest column is discarded.
  - With col_valid=0 the window holds.
- Output qualification: an accepted column with x>=2 and y>=2 completes a window centred at (x-1, y-1).
  - Only such columns produce output.
  - Columns with x<2 refill the window after a line wrap, so no stale columns from the previous line reach an output.
  - Border pixels (row 0, row PIC_HEIGHT-1, column 0, column PIC_WIDTH-1) produce no output.
  - Output count per frame: (PIC_WIDTH-2)*(PIC_HEIGHT-2).
- Arithmetic: pix_out is the unsigned minimum of the 9 window values, computed as a compare tree.
  - Ties take either operand; the result is identical.
  - No width growth.
- col_valid sampled outside RUN: no effect on counters, window or outputs.
- fifo_rst_busy sampled outside WAIT: ignored.

## Timing
- Reset values:
  - rst_fifo=0, ready=0, valid_out=0, pix_out=0, frame_done=0.
  - Window and counters are 0.
- Latency: the accepted column at cycle n that completes a window gives valid_out=1 with its pix_out at cycle n+2, i.e. window register at n+1 and min register at n+2.
- Throughput: one output per accepted column; arbitrary col_valid gaps are allowed. valid_out is a single-cycle pulse per window and pix_out holds between pulses.
- ready falls the cycle after the last column is accepted. A col_valid in that cycle or later is not accepted.
- frame_done: asserted in the same cycle as the final valid_out. FIFO_RST is entered on the next cycle, so rst_fifo=0 starts one cycle after frame_done.
- Frame-boundary dwell: rst_fifo stays low exactly RST_CYCLES clocks; WAIT then lasts at least 1 cycle.
- Async reset mid-frame:
  - All outputs return to their reset values immediately.
  - Counters and window clear.
  - FSM restarts in FIFO_RST; no frame_done is emitted for the partial frame.

## Test plan
- Reset/sequencing: PIC_WIDTH=5, PIC_HEIGHT=4, RST_CYCLES=4; hold fifo_rst_busy=1 for 10 cycles after rst_n rises.
  - Required: rst_fifo low for 4 cycles, then high.
  - Required: ready rises exactly 1 cycle after the first sampled fifo_rst_busy=0.
- Ramp frame: col_bot=10*y+x, col_mid=col_bot-10, col_top=col_bot-20, col_valid continuous.
  - Required: exactly 6 valid_out pulses.
  - Required: pix_out values 0,1,2,10,11,12, each 2 cycles after its completing column.
  - Required: frame_done coincident with the value 12.
- Gapped input: same frame with col_valid toggled 1,0,0,1,...
  - Required: same 6 values in the same order, each still 2 cycles after its accepted column.
- Single dark pixel: all 200 except col_mid=3 at x=2, y=2.
  - Required: outputs for centres (1,1),(2,1),(3,1) equal 3; the other three equal 200.
- Back-to-back frames: second frame presented as soon as ready rises.
  - Required: FIFO_RST lasts 4 cycles between frames; second frame's outputs match the first.
  - Required: col_valid during DRAIN or FIFO_RST is ignored, producing no extra valid_out.
- Mid-frame reset: assert rst_n=0 at x=3, y=2.
  - Required: valid_out/frame_done drop immediately and rst_fifo=0.
  - Required: next frame produces the full 6 outputs correctly.
